seg_scan_driver: RTL

//  Downstream consumer of the 4-bit add/subtract stage. Captures a result (total, carry/borrow, overflow)

---
 rtl/seg_scan_driver_pkg.sv | 29 ++
 rtl/seg_scan_driver_if.sv | 16 +
 rtl/seg_scan_driver_hex7_decode.sv | 9 +
 rtl/seg_scan_driver.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Glyph table, digit slot indices and the captured-result record.
package seg_pkg;

   typedef enum logic [0:0] {BLANK, SHOW} scan_state_t;

   // Active-high segments, bit 0 = a ... bit 6 = g
   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   localparam logic [6:0] SEG_MINUS = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [1:0] DIG_TOTAL = 2'd0;
   localparam logic [1:0] DIG_B     = 2'd1;
   localparam logic [1:0] DIG_A     = 2'd2;
   localparam logic [1:0] DIG_STAT  = 2'd3;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] total;
      logic       carry;
      logic       ov;
      logic       sub;
   } seg_data_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Result bus from the add/sub stage plus the display outputs of the scan driver.
interface seg_scan_driver_if;
   logic       load;
   logic [3:0] total;
   logic       carry;
   logic       ov;
   logic [3:0] a;
   logic [3:0] b;
   logic       sub;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   modport master (output load, total, carry, ov, a, b, sub, input seg, dp, an);
   modport slave  (input load, total, carry, ov, a, b, sub, output seg, dp, an);
endinterface

// File: rtl/seg_scan_driver_hex7_decode.sv
// Combinational 4-bit to 7-segment hex glyph lookup.
module hex7_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);
   assign glyph = SEG_HEX[nibble];
endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-seg driver with inter-digit blanking for the add/sub result.
// Optional SEG_BLINK_OV_EN: blink the whole display while the shown result has overflow set.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYC    = 64,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input logic            clk,
   input logic            rst_n,
   seg_scan_driver_if.slave bus
);

   if (SCAN_DIV < 1 || BLANK_CYC < 1 || BLINK_FRAMES < 1) begin : g_param_check
      $error("seg_scan_driver: SCAN_DIV, BLANK_CYC and BLINK_FRAMES must be >= 1");
   end

   localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BlankW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam int unsigned CntW   = (ScanW > BlankW) ? ScanW : BlankW;
   localparam logic [CntW-1:0] ScanLast  = CntW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

   scan_state_t     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   seg_data_t       shadow_q, shadow_d, disp_q, disp_d;
   logic            pend_q, pend_d, valid_q, valid_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic [3:0]      an_q, an_d;
   logic            copy, wrap, lit;
   logic [3:0]      nibble;
   logic [6:0]      glyph;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntW'(1);
      idx_d   = idx_q;
      unique case (state_q)
         BLANK: if (cnt_q == BlankLast) begin
            state_d = SHOW;
            cnt_d   = '0;
         end
         SHOW: if (cnt_q == ScanLast) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
         end
      endcase
   end

   // The copy edge reads shadow_q, so a load on that same edge stays pending.
   assign copy = (state_q == BLANK) && (cnt_q == BlankLast) && pend_q;
   assign wrap = (state_q == SHOW) && (cnt_q == ScanLast) && (idx_q == DIG_STAT);

   always_comb begin
      shadow_d = shadow_q;
      if (bus.load) begin
         shadow_d = '{a: bus.a, b: bus.b, total: bus.total, carry: bus.carry, ov: bus.ov,
                      sub: bus.sub};
      end
      pend_d  = bus.load | (pend_q & ~copy);
      disp_d  = copy ? shadow_q : disp_q;
      valid_d = valid_q | copy;
   end

`ifdef SEG_BLINK_OV_EN
   localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

   logic [FrameW-1:0] frame_q, frame_d;
   logic              phase_q, phase_d;

   always_comb begin
      frame_d = frame_q;
      phase_d = phase_q;
      if (copy) begin
         frame_d = '0;
         phase_d = 1'b1;
      end else if (wrap) begin
         if (frame_q == FrameLast) begin
            frame_d = '0;
            phase_d = ~phase_q;
         end else begin
            frame_d = frame_q + FrameW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
         phase_q <= 1'b1;
      end else begin
         frame_q <= frame_d;
         phase_q <= phase_d;
      end
   end

   assign lit = phase_d | ~disp_d.ov;
`else
   logic unused_wrap;
   assign unused_wrap = wrap;
   assign lit = 1'b1;
`endif

   always_comb begin
      nibble = 4'h0;
      unique case (idx_d)
         DIG_TOTAL: nibble = disp_d.total;
         DIG_B:     nibble = disp_d.b;
         DIG_A:     nibble = disp_d.a;
         DIG_STAT:  nibble = 4'h0;
      endcase
   end

   hex7_decode u_hex7_decode (
      .nibble (nibble),
      .glyph  (glyph)
   );

   always_comb begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b0;
      an_d  = 4'b0000;
      if (state_d == SHOW) begin
         if (lit) an_d = 4'(1) << idx_d;
         if (valid_d) begin
            unique case (idx_d)
               DIG_TOTAL: begin seg_d = glyph; dp_d = disp_d.ov; end
               DIG_B, DIG_A: seg_d = glyph;
               DIG_STAT: begin
                  seg_d = disp_d.sub ? SEG_MINUS : SEG_BLANK;
                  dp_d  = disp_d.carry;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BLANK;
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         disp_q   <= '0;
         pend_q   <= 1'b0;
         valid_q  <= 1'b0;
         seg_q    <= '0;
         dp_q     <= 1'b0;
         an_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         valid_q  <= valid_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
   assign bus.an  = an_q;

endmodule
